// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg : length codes, FSM states and owner codes           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int         c_ram_data_w = 8;

  localparam logic [1:0] c_len_b = 2'b00;
  localparam logic [1:0] c_len_h = 2'b01;
  localparam logic [1:0] c_len_w = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // The reserved code 2'b11 moves a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      c_len_b: n = 3'd1;
      c_len_h: n = 3'd2;
      c_len_w: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : IF, MEM and byte-RAM signals of the memory arbiter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import mem_arbiter_pkg::*;

  logic                    if_req_i;
  logic [ADDR_W-1:0]       if_addr_i;
  logic [31:0]             if_data_o;
  logic                    if_done_o;
  logic                    flush_i;
  logic                    mem_req_i;
  logic                    mem_we_i;
  logic [1:0]              mem_len_i;
  logic [ADDR_W-1:0]       mem_addr_i;
  logic [31:0]             mem_wdata_i;
  logic [31:0]             mem_rdata_o;
  logic                    mem_done_o;
  logic [ADDR_W-1:0]       ram_a_o;
  logic [c_ram_data_w-1:0] ram_dout_o;
  logic                    ram_wr_o;
  logic [c_ram_data_w-1:0] ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    output ram_a_o, ram_dout_o, ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
    input  ram_a_o, ram_dout_o, ram_wr_o
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : serialises IF fetches and MEM loads/stores onto a      |
// | byte-wide RAM, little-endian, MEM has priority. Revision: 1.0        |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t        r_state,     w_state;
  owner_t            r_owner,     w_owner;
  logic [ADDR_W-1:0] r_addr,      w_addr;
  logic [2:0]        r_nbytes,    w_nbytes;
  logic [31:0]       r_wdata,     w_wdata;
  logic [2:0]        r_cnt,       w_cnt;
  logic [31:0]       r_rbuf,      w_rbuf;
  logic [31:0]       r_if_data,   w_if_data;
  logic              r_if_done,   w_if_done;
  logic [31:0]       r_mem_rdata, w_mem_rdata;
  logic              r_mem_done,  w_mem_done;
  logic [ADDR_W-1:0] r_ram_a,     w_ram_a;
  logic [7:0]        r_ram_dout,  w_ram_dout;
  logic              r_ram_wr,    w_ram_wr;

  logic [2:0]        w_cnt_inc;
  logic [1:0]        w_lane;
  logic [31:0]       w_rbuf_ins;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_wbyte;

  always_comb begin
    w_cnt_inc   = r_cnt + 3'd1;
    // The RAM answers one cycle late, so the byte arriving now belongs to lane r_cnt-1.
    w_lane      = r_cnt[1:0] - 2'd1;
    w_rbuf_ins  = r_rbuf;
    w_rbuf_ins[{w_lane, 3'b000} +: 8] = bus.ram_din_i;
    w_next_addr = r_addr + {{(ADDR_W-3){1'b0}}, w_cnt_inc};
    w_wbyte     = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];

    w_state     = r_state;
    w_owner     = r_owner;
    w_addr      = r_addr;
    w_nbytes    = r_nbytes;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_rbuf      = r_rbuf;
    w_if_data   = r_if_data;
    w_if_done   = 1'b0;
    w_mem_rdata = r_mem_rdata;
    w_mem_done  = 1'b0;
    w_ram_a     = r_ram_a;
    w_ram_dout  = r_ram_dout;
    w_ram_wr    = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (bus.mem_req_i) begin
          w_owner  = OWN_MEM;
          w_addr   = bus.mem_addr_i;
          w_nbytes = len_to_bytes(bus.mem_len_i);
          w_wdata  = bus.mem_wdata_i;
          w_cnt    = 3'd0;
          w_rbuf   = 32'd0;
          w_ram_a  = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            w_ram_dout = bus.mem_wdata_i[7:0];
            w_ram_wr   = 1'b1;
            w_state    = ARB_WRITE;
          end else begin
            w_state    = ARB_READ;
          end
        end else if (bus.if_req_i && !bus.flush_i) begin
          w_owner  = OWN_IF;
          w_addr   = bus.if_addr_i;
          w_nbytes = 3'd4;
          w_cnt    = 3'd0;
          w_rbuf   = 32'd0;
          w_ram_a  = bus.if_addr_i;
          w_state  = ARB_READ;
        end
      end

      ARB_READ: begin
        if (r_owner == OWN_IF && bus.flush_i) begin
          w_state = ARB_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
          if (r_cnt != 3'd0) w_rbuf = w_rbuf_ins;
          if (w_cnt_inc < r_nbytes) w_ram_a = w_next_addr;
          if (r_cnt == r_nbytes) begin
            w_state = ARB_DONE;
            if (r_owner == OWN_IF) begin
              w_if_data  = w_rbuf_ins;
              w_if_done  = 1'b1;
            end else begin
              w_mem_rdata = w_rbuf_ins;
              w_mem_done  = 1'b1;
            end
          end
        end
      end

      ARB_WRITE: begin
        if (w_cnt_inc < r_nbytes) begin
          w_cnt      = w_cnt_inc;
          w_ram_a    = w_next_addr;
          w_ram_dout = w_wbyte;
          w_ram_wr   = 1'b1;
        end else begin
          w_state    = ARB_DONE;
          w_mem_done = 1'b1;
        end
      end

      // Requests are deliberately ignored here so a held request is not re-accepted.
      ARB_DONE: w_state = ARB_IDLE;

      default: w_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_nbytes    <= 3'd0;
      r_wdata     <= 32'd0;
      r_cnt       <= 3'd0;
      r_rbuf      <= 32'd0;
      r_if_data   <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_mem_done  <= 1'b0;
      r_ram_a     <= '0;
      r_ram_dout  <= 8'd0;
      r_ram_wr    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_addr      <= w_addr;
      r_nbytes    <= w_nbytes;
      r_wdata     <= w_wdata;
      r_cnt       <= w_cnt;
      r_rbuf      <= w_rbuf;
      r_if_data   <= w_if_data;
      r_if_done   <= w_if_done;
      r_mem_rdata <= w_mem_rdata;
      r_mem_done  <= w_mem_done;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
    end
  end

  assign bus.if_data_o   = r_if_data;
  assign bus.if_done_o   = r_if_done;
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.mem_done_o  = r_mem_done;
  assign bus.ram_a_o     = r_ram_a;
  assign bus.ram_dout_o  = r_ram_dout;
  assign bus.ram_wr_o    = r_ram_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed bench for mem_arbiter with a byte RAM model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [7:0]  ram [0:65535];
  logic        ld_en;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: one-cycle read latency; preload port used during reset.
  always @(posedge clk) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (bus.ram_wr_o) ram[bus.ram_a_o[15:0]] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    preload(16'h1000, 8'h13); preload(16'h1001, 8'h05);
    preload(16'h1002, 8'h00); preload(16'h1003, 8'h00);
    preload(16'h2000, 8'h11); preload(16'h2001, 8'h22);
    preload(16'h2002, 8'h33); preload(16'h2003, 8'h44);
    preload(16'h0000, 8'h93); preload(16'h0001, 8'h00);
    preload(16'h0002, 8'h00); preload(16'h0003, 8'h00);
    preload(16'h0004, 8'h5A); preload(16'hFFFF, 8'h77);
    for (int i = 16; i < 20; i++) preload(16'(i), 8'h00);
    for (int i = 32; i < 36; i++) preload(16'(i), 8'h00);
    n_total++;
    if ({bus.if_done_o, bus.mem_done_o, bus.ram_wr_o} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {bus.if_done_o, bus.mem_done_o, bus.ram_wr_o});
    else n_pass++;
    n_total++;
    if ({bus.ram_a_o, bus.ram_dout_o} !== 40'd0)
      $display("FAIL reset_ram_bus got %h want 0", {bus.ram_a_o, bus.ram_dout_o});
    else n_pass++;
    n_total++;
    if ({bus.if_data_o, bus.mem_rdata_o} !== 64'd0)
      $display("FAIL reset_data got %h want 0", {bus.if_data_o, bus.mem_rdata_o});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_fetch(input string tag);
    int          done_k = 0;
    int          done_n = 0;
    logic [31:0] data   = 32'd0;
    bit          wr_seen = 1'b0;
    bus.if_addr_i = 32'h1000;
    bus.if_req_i  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        n_total++;
        if (bus.ram_a_o !== 32'(32'h1000 + k - 1))
          $display("FAIL %s_addr k=%0d got %h want %h", tag, k, bus.ram_a_o, 32'(32'h1000 + k - 1));
        else n_pass++;
      end
      if (bus.ram_wr_o) wr_seen = 1'b1;
      if (bus.if_done_o) begin
        done_n++;
        if (done_k == 0) begin done_k = k; data = bus.if_data_o; end
        bus.if_req_i = 1'b0;
      end
    end
    bus.if_req_i = 1'b0;
    n_total++;
    if (done_k != 6 || done_n != 1)
      $display("FAIL %s_done got cycle %0d count %0d want cycle 6 count 1", tag, done_k, done_n);
    else n_pass++;
    n_total++;
    if (data !== 32'h0000_0513) $display("FAIL %s_data got %h want 00000513", tag, data);
    else n_pass++;
    n_total++;
    if (wr_seen) $display("FAIL %s_no_write got 1 want 0", tag);
    else n_pass++;
  endtask

  task automatic test_priority;
    int          mem_k = 0;
    int          if_k  = 0;
    logic [31:0] mdata = 32'd0;
    logic [31:0] idata = 32'd0;
    logic [31:0] a8    = 32'd0;
    bus.mem_we_i   = 1'b0;
    bus.mem_len_i  = 2'b10;
    bus.mem_addr_i = 32'h2000;
    bus.mem_req_i  = 1'b1;
    bus.if_addr_i  = 32'h0;
    bus.if_req_i   = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) a8 = bus.ram_a_o;
      if (bus.mem_done_o && mem_k == 0) begin mem_k = k; mdata = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
      if (bus.if_done_o && if_k == 0) begin if_k = k; idata = bus.if_data_o; bus.if_req_i = 1'b0; end
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    n_total++;
    if (mem_k != 6) $display("FAIL prio_mem_done got cycle %0d want 6", mem_k);
    else n_pass++;
    n_total++;
    if (mdata !== 32'h4433_2211) $display("FAIL prio_mem_data got %h want 44332211", mdata);
    else n_pass++;
    n_total++;
    if (a8 !== 32'h0) $display("FAIL prio_if_addr got %h want 00000000", a8);
    else n_pass++;
    n_total++;
    if (if_k != 13) $display("FAIL prio_if_done got cycle %0d want 13", if_k);
    else n_pass++;
    n_total++;
    if (idata !== 32'h0000_0093) $display("FAIL prio_if_data got %h want 00000093", idata);
    else n_pass++;
  endtask

  task automatic test_store_byte;
    int done_k = 0;
    bus.mem_we_i    = 1'b1;
    bus.mem_len_i   = 2'b00;
    bus.mem_addr_i  = 32'h3;
    bus.mem_wdata_i = 32'h1234_56AB;
    bus.mem_req_i   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.ram_wr_o !== (k == 1))
        $display("FAIL sb_wr k=%0d got %b want %b", k, bus.ram_wr_o, (k == 1));
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if ({bus.ram_a_o, bus.ram_dout_o} !== {32'h3, 8'hAB})
          $display("FAIL sb_bus got %h/%h want 00000003/ab", bus.ram_a_o, bus.ram_dout_o);
        else n_pass++;
      end
      if (bus.mem_done_o && done_k == 0) begin done_k = k; bus.mem_req_i = 1'b0; end
    end
    bus.mem_req_i = 1'b0;
    n_total++;
    if (done_k != 2) $display("FAIL sb_done got cycle %0d want 2", done_k);
    else n_pass++;
    n_total++;
    if ({ram[3], ram[4]} !== 16'hAB5A) $display("FAIL sb_ram got %h want ab5a", {ram[3], ram[4]});
    else n_pass++;
  endtask

  task automatic test_store_load;
    int          done_k = 0;
    logic [31:0] data   = 32'd0;
    logic [7:0]  exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    bus.mem_we_i    = 1'b1;
    bus.mem_len_i   = 2'b10;
    bus.mem_addr_i  = 32'h10;
    bus.mem_wdata_i = 32'hDEAD_BEEF;
    bus.mem_req_i   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        n_total++;
        if ({bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o} !== {1'b1, 32'(32'h10 + k - 1), exp_b[k-1]})
          $display("FAIL sw_byte k=%0d got %b/%h/%h want 1/%h/%h", k, bus.ram_wr_o, bus.ram_a_o,
                   bus.ram_dout_o, 32'(32'h10 + k - 1), exp_b[k-1]);
        else n_pass++;
      end
      if (bus.mem_done_o && done_k == 0) begin done_k = k; bus.mem_req_i = 1'b0; end
    end
    bus.mem_req_i = 1'b0;
    n_total++;
    if (done_k != 5) $display("FAIL sw_done got cycle %0d want 5", done_k);
    else n_pass++;

    done_k = 0;
    bus.mem_we_i   = 1'b0;
    bus.mem_len_i  = 2'b01;
    bus.mem_addr_i = 32'h12;
    bus.mem_req_i  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.mem_done_o && done_k == 0) begin done_k = k; data = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
    end
    bus.mem_req_i = 1'b0;
    n_total++;
    if (done_k != 4) $display("FAIL lh_done got cycle %0d want 4", done_k);
    else n_pass++;
    n_total++;
    if (data !== 32'h0000_DEAD) $display("FAIL lh_data got %h want 0000dead", data);
    else n_pass++;
  endtask

  task automatic test_flush_idle;
    int          done_k = 0;
    int          if_n   = 0;
    logic [31:0] data   = 32'd0;
    bus.flush_i    = 1'b1;
    bus.if_addr_i  = 32'h1000;
    bus.if_req_i   = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_len_i  = 2'b00;
    bus.mem_addr_i = 32'h11;
    bus.mem_req_i  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.if_done_o) if_n++;
      if (bus.mem_done_o && done_k == 0) begin done_k = k; data = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
    end
    n_total++;
    if (done_k != 3) $display("FAIL fi_mem_done got cycle %0d want 3", done_k);
    else n_pass++;
    n_total++;
    if (data !== 32'h0000_00BE) $display("FAIL fi_mem_data got %h want 000000be", data);
    else n_pass++;
    n_total++;
    if (if_n != 0 || bus.ram_a_o !== 32'h11)
      $display("FAIL fi_if_blocked got done %0d addr %h want done 0 addr 00000011", if_n, bus.ram_a_o);
    else n_pass++;
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    bus.flush_i   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_mid;
    int          done_k = 0;
    int          done_n = 0;
    logic [31:0] data   = 32'd0;
    logic [31:0] a5     = 32'd0;
    bus.if_addr_i = 32'h1000;
    bus.if_req_i  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 5) a5 = bus.ram_a_o;
      if (bus.if_done_o) begin
        done_n++;
        if (done_k == 0) begin done_k = k; data = bus.if_data_o; end
        bus.if_req_i = 1'b0;
      end
      if (k == 3) bus.flush_i = 1'b1;
      if (k == 4) begin bus.flush_i = 1'b0; bus.if_addr_i = 32'h0; end
    end
    bus.if_req_i = 1'b0;
    n_total++;
    if (a5 !== 32'h0) $display("FAIL fm_new_addr got %h want 00000000", a5);
    else n_pass++;
    n_total++;
    if (done_k != 10 || done_n != 1)
      $display("FAIL fm_done got cycle %0d count %0d want cycle 10 count 1", done_k, done_n);
    else n_pass++;
    // Bytes 0..3 are now 93,00,00,AB after the earlier byte store.
    n_total++;
    if (data !== 32'hAB00_0093) $display("FAIL fm_data got %h want ab000093", data);
    else n_pass++;
  endtask

  task automatic test_flush_last;
    int done_n = 0;
    bus.if_addr_i = 32'h1000;
    bus.if_req_i  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.if_done_o) done_n++;
      if (k == 5) bus.flush_i = 1'b1;
      if (k == 6) begin bus.flush_i = 1'b0; bus.if_req_i = 1'b0; end
    end
    n_total++;
    if (done_n != 0) $display("FAIL fl_no_done got %0d pulses want 0", done_n);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int          done_k = 0;
    logic [31:0] data   = 32'd0;
    logic [31:0] a1 = 32'd0;
    logic [31:0] a2 = 32'd1;
    bus.mem_we_i   = 1'b0;
    bus.mem_len_i  = 2'b11;
    bus.mem_addr_i = 32'hFFFF_FFFF;
    bus.mem_req_i  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a1 = bus.ram_a_o;
      if (k == 2) a2 = bus.ram_a_o;
      if (bus.mem_done_o && done_k == 0) begin done_k = k; data = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
    end
    bus.mem_req_i = 1'b0;
    n_total++;
    if (a1 !== 32'hFFFF_FFFF || a2 !== 32'h0)
      $display("FAIL wrap_addr got %h,%h want ffffffff,00000000", a1, a2);
    else n_pass++;
    n_total++;
    if (done_k != 6 || data !== 32'h0000_9377)
      $display("FAIL wrap_data got cycle %0d data %h want cycle 6 data 00009377", done_k, data);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int done_n = 0;
    bus.mem_we_i    = 1'b1;
    bus.mem_len_i   = 2'b10;
    bus.mem_addr_i  = 32'h20;
    bus.mem_wdata_i = 32'hCAFE_F00D;
    bus.mem_req_i   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_done_o) done_n++;
      if (k == 2) begin
        n_total++;
        if ({bus.ram_wr_o, bus.ram_a_o} !== {1'b1, 32'h21})
          $display("FAIL rm_pre got %b/%h want 1/00000021", bus.ram_wr_o, bus.ram_a_o);
        else n_pass++;
        rst = 1'b1;
      end
      if (k == 3) begin
        n_total++;
        if ({bus.ram_wr_o, bus.mem_done_o, bus.if_done_o, bus.ram_a_o, bus.ram_dout_o,
             bus.if_data_o, bus.mem_rdata_o} !== 107'd0)
          $display("FAIL rm_outputs got wr %b done %b/%b a %h d %h if %h mem %h want all 0",
                   bus.ram_wr_o, bus.mem_done_o, bus.if_done_o, bus.ram_a_o, bus.ram_dout_o,
                   bus.if_data_o, bus.mem_rdata_o);
        else n_pass++;
        rst = 1'b0;
        bus.mem_req_i = 1'b0;
      end
    end
    n_total++;
    if (done_n != 0) $display("FAIL rm_no_done got %0d pulses want 0", done_n);
    else n_pass++;
    test_if_fetch("rm_fetch");
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst             = 1'b1;
    ld_en           = 1'b0;
    ld_a            = 16'd0;
    ld_d            = 8'd0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'd0;
    bus.flush_i     = 1'b0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = 2'b00;
    bus.mem_addr_i  = 32'd0;
    bus.mem_wdata_i = 32'd0;
    @(negedge clk);
    test_reset;
    test_if_fetch("fetch");
    test_priority;
    test_store_byte;
    test_store_load;
    test_flush_idle;
    test_flush_mid;
    test_flush_last;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
